uart_rx_fifo: RTL and testbench

Parametrised, synthesizable UART receiver with an integrated receive FIFO. It supersedes the fixed-format simulation receiver on the SoC `uart_tx` line, and adds the following:
- configurable frame format
- optional parity checking
- per-word frame and parity error flags
- a sticky overrun flag
- a valid/ready read port

It sits in the peripheral subsystem behind the register interface and is also instantiated in benches as the UART monitor.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_sync_fifo.sv | 69 ++++++
 rtl/uart_rx_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding, parity
// mode constants and bit-period arithmetic.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Rounded clock cycles per bit.
  function automatic int bit_cycles(input int clk_freq, input int baudrate);
    return (clk_freq + baudrate / 2) / baudrate;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Generic single-clock FIFO; read data is the combinational head, one-cycle write-to-read.
// A push while full is accepted only when a pop happens in the same cycle, otherwise it is ignored.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with receive FIFO; word visible on valid_o the cycle after the word_done_o pulse.
// Consumer pops with ready_i; a word arriving while full (and not popped) is dropped, setting overrun_o.
// Parity state/checker compiled in only with UART_RX_PARITY_EN.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 8_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  input  logic                          ready_i,
  input  logic                          clear_i,
  output logic                          valid_o,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          word_done_o,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int          BIT_CYCLES = bit_cycles(CLK_FREQ, BAUDRATE);
  localparam int          HALF       = BIT_CYCLES / 2;
  localparam logic [15:0] BIT_LD     = 16'(BIT_CYCLES);
  localparam logic [15:0] HALF_LD    = 16'(HALF);
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR_ACTIVE = (PARITY != PARITY_NONE);
  localparam int          FW         = DATA_BITS + 2;
`else
  localparam int          FW         = DATA_BITS + 1;
`endif

  logic [1:0]           sync_q, sync_d;
  logic                 rx_dly_q, rx_dly_d;
  logic                 rx_s;
  uart_rx_state_e       state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push_q, push_d;
  logic [FW-1:0]        push_dat_q, push_dat_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
`endif
  logic                 expire;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]        fifo_head;

  assign rx_s   = sync_q[1];
  assign expire = (cnt_q == 16'd1);

  always_comb begin
    sync_d     = {sync_q[0], rx_i};
    rx_dly_d   = rx_s;
    state_d    = state_q;
    cnt_d      = (cnt_q == 16'd0) ? 16'd0 : cnt_q - 16'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push_d     = 1'b0;
    push_dat_d = push_dat_q;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Edge detect, so a line stuck low never re-arms until it recovers.
        if (rx_en_i && rx_dly_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF_LD;
        end
      end
      ST_START: begin
        if (expire) begin
          if (!rx_s) begin
            state_d   = ST_DATA;
            cnt_d     = BIT_LD;
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            perr_d    = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (expire) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d     = BIT_LD;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PAR_ACTIVE ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (expire) begin
          perr_d  = (^shift_q ^ rx_s) ^ (PARITY == PARITY_ODD);
          cnt_d   = BIT_LD;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (expire) begin
          push_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          push_dat_d = {perr_q, !rx_s, shift_q};
`else
          push_dat_d = {!rx_s, shift_q};
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_pop = !fifo_empty && ready_i;

  always_comb begin
    ovr_d = ovr_q;
    if (clear_i) begin
      ovr_d = 1'b0;
    end
    if (push_q && fifo_full && !fifo_pop) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q     <= 2'b11;
      rx_dly_q   <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      sync_q     <= sync_d;
      rx_dly_q   <= rx_dly_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
      push_dat_q <= push_dat_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  uart_rx_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .reset   (reset),
    .push_i  (push_q),
    .wdata_i (push_dat_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  // Head is masked while empty so stale storage never shows on the outputs.
  assign valid_o     = !fifo_empty;
  assign data_o      = fifo_empty ? '0 : fifo_head[DATA_BITS-1:0];
  assign frame_err_o = !fifo_empty && fifo_head[DATA_BITS];
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = !fifo_empty && fifo_head[DATA_BITS+1];
`else
  assign parity_err_o = 1'b0;
`endif
  assign word_done_o = push_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default timing (69 cycles per bit).
module tb_uart_rx_fifo;

  localparam int BIT = 69;
`ifdef UART_RX_PARITY_EN
  localparam int TB_PARITY = 1;
`else
  localparam int TB_PARITY = 0;
`endif

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       rx_i = 1'b1;
  logic       rx_en_i = 1'b1;
  logic       ready_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       valid_o;
  logic [7:0] data_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       word_done_o;
  logic       overrun_o;
  logic [2:0] count_o;

  uart_rx_fifo #(
    .CLK_FREQ   (8_000_000),
    .BAUDRATE   (115200),
    .DATA_BITS  (8),
    .PARITY     (TB_PARITY),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .rx_i         (rx_i),
    .rx_en_i      (rx_en_i),
    .ready_i      (ready_i),
    .clear_i      (clear_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .word_done_o  (word_done_o),
    .overrun_o    (overrun_o),
    .count_o      (count_o)
  );

  always #5 clk_in = ~clk_in;

  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  logic       wd_prev = 1'b0;
  logic       pre_valid = 1'b0;
  logic       post_valid = 1'b0;
  logic [2:0] post_count = '0;

  // Records the FIFO state in the pulse cycle and the cycle after it.
  always @(negedge clk_in) begin
    if (wd_prev) begin
      post_valid = valid_o;
      post_count = count_o;
    end
    wd_prev = word_done_o;
    if (word_done_o) begin
      done_cnt  = done_cnt + 1;
      pre_valid = valid_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    hold(1'b0, BIT);
    for (int b = 0; b < 8; b++) hold(d[b], BIT);
`ifdef UART_RX_PARITY_EN
    hold(par, BIT);
`else
    if (par) rx_i = 1'b1;
`endif
    hold(stop, BIT);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
    hold(1'b1, 20);
  endtask

  task automatic pop_one();
    ready_i = 1'b1;
    @(posedge clk_in);
    #1;
    ready_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    logic       en;
    logic       exp_word;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int         base;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_count", count_o, 0);
    check("rst_word_done", word_done_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    check("rst_parity_err", parity_err_o, 0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    hold(1'b1, 10);

    for (int i = 0; i < 6; i++) begin
      base    = done_cnt;
      rx_en_i = vecs[i].en;
      send_frame(vecs[i].dat, ^vecs[i].dat, vecs[i].stop);
      hold(1'b1, 20);
      rx_en_i = 1'b1;
      @(negedge clk_in);
      check("vec_words", done_cnt - base, 32'(vecs[i].exp_word));
      if (vecs[i].exp_word) begin
        check("vec_valid_in_T", pre_valid, 0);
        check("vec_valid_T1", post_valid, 1);
        check("vec_count_T1", post_count, 1);
        check("vec_data", data_o, vecs[i].dat);
        check("vec_frame_err", frame_err_o, vecs[i].exp_ferr);
        check("vec_parity_err", parity_err_o, 0);
        pop_one();
        @(negedge clk_in);
        check("vec_valid_after_pop", valid_o, 0);
        check("vec_count_after_pop", count_o, 0);
      end else begin
        check("vec_idle_valid", valid_o, 0);
      end
    end

    // Frame error followed by a long low line: only one word.
    base = done_cnt;
    d = 8'h3C;
    send_frame(d, ^d, 1'b0);
    hold(1'b0, 200);
    @(negedge clk_in);
    check("ferr_words", done_cnt - base, 1);
    check("ferr_flag", frame_err_o, 1);
    check("ferr_data", data_o, 8'h3C);
    check("ferr_count", count_o, 1);
    hold(1'b1, 40);
    @(negedge clk_in);
    check("ferr_no_rearm", done_cnt - base, 1);
    check("ferr_count_hold", count_o, 1);
    pop_one();

    // Short glitch, then a good frame.
    base = done_cnt;
    hold(1'b0, 20);
    hold(1'b1, 100);
    @(negedge clk_in);
    check("glitch_words", done_cnt - base, 0);
    check("glitch_valid", valid_o, 0);
    send(8'h5A);
    @(negedge clk_in);
    check("post_glitch_words", done_cnt - base, 1);
    check("post_glitch_data", data_o, 8'h5A);
    pop_one();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    hold(1'b1, 20);
    @(negedge clk_in);
    check("par_bad_flag", parity_err_o, 1);
    check("par_bad_data", data_o, 8'h07);
    pop_one();
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 20);
    @(negedge clk_in);
    check("par_good_flag", parity_err_o, 0);
    check("par_good_data", data_o, 8'h07);
    pop_one();
`endif

    // Overrun: five words into a four-entry FIFO with no reader.
    base = done_cnt;
    for (int k = 1; k <= 5; k++) send(8'(k));
    @(negedge clk_in);
    check("ovr_words", done_cnt - base, 5);
    check("ovr_count", count_o, 4);
    check("ovr_flag", overrun_o, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      check("ovr_read_valid", valid_o, 1);
      check("ovr_read_data", data_o, k);
      @(posedge clk_in);
      #1;
      pop_one();
    end
    @(negedge clk_in);
    check("ovr_drained", valid_o, 0);
    check("ovr_sticky", overrun_o, 1);
    @(posedge clk_in);
    #1;
    clear_i = 1'b1;
    @(posedge clk_in);
    #1;
    clear_i = 1'b0;
    @(negedge clk_in);
    check("ovr_cleared", overrun_o, 0);

    // Reset in the middle of the 4th data bit with one word queued.
    send(8'h11);
    @(negedge clk_in);
    check("pre_rst_count", count_o, 1);
    @(posedge clk_in);
    #1;
    d = 8'h5A;
    hold(1'b0, BIT);
    for (int b = 0; b < 3; b++) hold(d[b], BIT);
    hold(d[3], BIT / 2);
    reset = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_data", data_o, 0);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_word_done", word_done_o, 0);
    check("mid_rst_frame_err", frame_err_o, 0);
    rx_i = 1'b1;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    hold(1'b1, 20);
    base = done_cnt;
    send(8'h5A);
    @(negedge clk_in);
    check("post_rst_words", done_cnt - base, 1);
    check("post_rst_data", data_o, 8'h5A);
    check("post_rst_frame_err", frame_err_o, 0);
    check("post_rst_count", count_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
